flexsoc_rst_seq: RTL
====================

// Module: flexsoc_rst_seq
// PURPOSE
//  Reset sequencer for the FPGA top: combines pushbutton, PLL lock and core SYSRESETREQ into staged resets.
//  Drives PORESETn (debug + system) and HRESETn (system only, SYSRESETREQ domain) for flexsoc_cm3.
//  Sits between the PLLs/button and the SoC. Replaces the ad-hoc reset counter in the FPGA wrapper.
// PARAMETERS
//  NUM_LOCK     2   number of PLL lock inputs, all must be high to leave reset
//  SYNC_STAGES  2   synchronizer depth for BTN and LOCKED (>=2)
//  POR_CYCLES   15  CLK cycles PORESETn held low after all hold sources clear
//  SYS_CYCLES   8   CLK cycles HRESETn held low after PORESETn release / after SYSRESETREQ
//  DEB_CYCLES   1024 debounce window; used only with RSTSEQ_DEBOUNCE_EN
// PORTS
//  CLK          in   1         HCLK-domain clock
//  RESET        in   1         async active-high reset
//  BTN          in   1         raw pushbutton, active-high, async
//  LOCKED       in   NUM_LOCK  PLL lock flags, async
//  SYSRESETREQ  in   1         core system reset request, CLK-synchronous
//  PORESETn     out  1         power-on reset to SoC, active-low
//  HRESETn      out  1         system reset to SoC, active-low
//  RST_CAUSE    out  4         [0] RESET, [1] button, [2] lock loss, [3] SYSRESETREQ
// BEHAVIOUR
//  Reset is async active-high on RESET. While RESET: state=S_POR, counter=POR_CYCLES,
//   PORESETn=0, HRESETn=0, RST_CAUSE=4'b0001, all sync flops for BTN/LOCKED = 0.
//  BTN and each LOCKED bit pass through SYNC_STAGES flops. hold = btn_s | ~&lock_s.
//  PORESETn/HRESETn are dedicated flops updated on the same edge as state: glitch-free.
//  States:
//   S_POR: PORESETn=0,HRESETn=0. hold -> ctr<=POR_CYCLES; else ctr!=0 -> ctr--;
//          else -> S_SYS, ctr<=SYS_CYCLES, PORESETn<=1.
//   S_SYS: PORESETn=1,HRESETn=0. ctr!=0 -> ctr--; else -> S_RUN, HRESETn<=1.
//   S_RUN: both high. SYSRESETREQ -> S_SWRST, ctr<=SYS_CYCLES, HRESETn<=0.
//   S_SWRST: PORESETn=1,HRESETn=0. SYSRESETREQ still high -> ctr<=SYS_CYCLES;
//          else ctr!=0 -> ctr--; else -> S_RUN, HRESETn<=1.
//  hold in S_SYS/S_RUN/S_SWRST -> S_POR, ctr<=POR_CYCLES, PORESETn<=0, HRESETn<=0 (priority
//   over SYSRESETREQ in the same cycle).
//  SYSRESETREQ ignored in S_POR and S_SYS.
//  RST_CAUSE overwritten on each entry to S_POR/S_SWRST with OR of causes active that cycle
//   ([1] btn_s, [2] ~&lock_s, [3] SYSRESETREQ); held otherwise.
//  Latency: hold clear from RESET deassert -> PORESETn rises at edge SYNC_STAGES+POR_CYCLES+1;
//   HRESETn rises SYS_CYCLES+1 edges after PORESETn.
//  ctr width = $clog2(max(POR_CYCLES,SYS_CYCLES,DEB_CYCLES)+1); no wrap, saturates at 0.
//  Lock glitch shorter than 1 CLK may be missed; any sampled low restarts S_POR fully.
// CONFIGURATION
//  RSTSEQ_DEBOUNCE_EN defined: btn_s replaced by debounced value; changes only after synced
//   BTN differs from debounced value for DEB_CYCLES consecutive cycles; debounced resets to 0.
//  Not defined: btn_s = synchronizer output directly; DEB_CYCLES unused.
// TESTING
//  LOCKED=2'b11, BTN=0 from start, release RESET -> PORESETn=1 at edge 18, HRESETn=1 at edge 27, RST_CAUSE=4'b0001.
//  LOCKED=2'b01 for 40 cycles then 2'b11 -> PORESETn low until 18 edges after LOCKED[1] rise.
//  In S_RUN pulse SYSRESETREQ 1 cycle -> HRESETn low 9 cycles, PORESETn stays 1, RST_CAUSE=4'b1000.
//  In S_SWRST drop LOCKED[0] -> PORESETn=0 within 3 edges, RST_CAUSE=4'b0100, full POR sequence repeats.
//  BTN and SYSRESETREQ asserted same cycle in S_RUN -> S_POR, RST_CAUSE=4'b1010.
//  DEBOUNCE_EN, DEB_CYCLES=16: 10-cycle BTN pulse -> no reset; 20-cycle pulse -> PORESETn falls.

Source files
------------

// File: rtl/flexsoc_rst_seq.sv
// flexsoc_rst_seq: staged PORESETn/HRESETn sequencer from button, PLL locks and SYSRESETREQ.
// Define RSTSEQ_DEBOUNCE_EN to debounce the synchronized button over DEB_CYCLES cycles.
module flexsoc_rst_seq #(
    parameter int NUM_LOCK    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int POR_CYCLES  = 15,
    parameter int SYS_CYCLES  = 8,
    parameter int DEB_CYCLES  = 1024
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                BTN,
    input  logic [NUM_LOCK-1:0] LOCKED,
    input  logic                SYSRESETREQ,
    output logic                PORESETn,
    output logic                HRESETn,
    output logic [3:0]          RST_CAUSE
);
    localparam int MAXC = (POR_CYCLES > SYS_CYCLES) ?
                          ((POR_CYCLES > DEB_CYCLES) ? POR_CYCLES : DEB_CYCLES) :
                          ((SYS_CYCLES > DEB_CYCLES) ? SYS_CYCLES : DEB_CYCLES);
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [1:0] S_POR   = 2'd0;
    localparam logic [1:0] S_SYS   = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_SWRST = 2'd3;
    logic [SYNC_STAGES-1:0]               btn_q;
    logic [SYNC_STAGES-1:0][NUM_LOCK-1:0] lock_q;
    logic [NUM_LOCK-1:0]                  lock_s;
    logic                                 btn_s;
    logic                                 hold;
    logic                                 sw_ok;
    logic [1:0]                           state;
    logic [CW-1:0]                        ctr;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            btn_q  <= '0;
            lock_q <= '0;
        end else begin
            btn_q  <= {btn_q[SYNC_STAGES-2:0], BTN};
            lock_q <= {lock_q[SYNC_STAGES-2:0], LOCKED};
        end
    end
`ifdef RSTSEQ_DEBOUNCE_EN
    logic          btn_deb;
    logic [CW-1:0] deb_ctr;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            btn_deb <= 1'b0;
            deb_ctr <= '0;
        end else if (btn_q[SYNC_STAGES-1] == btn_deb) begin
            deb_ctr <= '0;
        end else if (deb_ctr == CW'(DEB_CYCLES - 1)) begin
            btn_deb <= ~btn_deb;
            deb_ctr <= '0;
        end else begin
            deb_ctr <= deb_ctr + 1'b1;
        end
    end
    assign btn_s = btn_deb;
`else
    assign btn_s = btn_q[SYNC_STAGES-1];
`endif
    assign lock_s = lock_q[SYNC_STAGES-1];
    assign hold   = btn_s | ~&lock_s;
    // SYSRESETREQ only counts as a cause once the system domain has been running
    assign sw_ok  = (state == S_RUN) || (state == S_SWRST);
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_POR;
            ctr       <= CW'(POR_CYCLES);
            PORESETn  <= 1'b0;
            HRESETn   <= 1'b0;
            RST_CAUSE <= 4'b0001;
        end else if (hold && state != S_POR) begin
            state     <= S_POR;
            ctr       <= CW'(POR_CYCLES);
            PORESETn  <= 1'b0;
            HRESETn   <= 1'b0;
            RST_CAUSE <= {sw_ok & SYSRESETREQ, ~&lock_s, btn_s, 1'b0};
        end else begin
            case (state)
                S_POR: begin
                    if (hold) begin
                        ctr <= CW'(POR_CYCLES);
                    end else if (ctr != '0) begin
                        ctr <= ctr - 1'b1;
                    end else begin
                        state    <= S_SYS;
                        ctr      <= CW'(SYS_CYCLES);
                        PORESETn <= 1'b1;
                    end
                end
                S_SYS: begin
                    if (ctr != '0) begin
                        ctr <= ctr - 1'b1;
                    end else begin
                        state   <= S_RUN;
                        HRESETn <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (SYSRESETREQ) begin
                        state     <= S_SWRST;
                        ctr       <= CW'(SYS_CYCLES);
                        HRESETn   <= 1'b0;
                        RST_CAUSE <= 4'b1000;
                    end
                end
                default: begin
                    if (SYSRESETREQ) begin
                        ctr <= CW'(SYS_CYCLES);
                    end else if (ctr != '0) begin
                        ctr <= ctr - 1'b1;
                    end else begin
                        state   <= S_RUN;
                        HRESETn <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
